uart_rx_byte: RTL and testbench

- 8N1 UART receiver, the receive-side counterpart of the team's 1 Mbaud emitter UART. Both sides use the same clocks-per-bit divider.
- Samples an asynchronous serial line and recovers bytes at mid-bit.
- Delivers each byte on a valid/ready handshake with framing and overrun flags.
- Sits between the board RX pin and command/loopback logic, e.g. host control of the TDC capture path.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rx_sync.sv | 17 +
 rtl/uart_rx_byte.sv | 88 ++++++++
 tb/tb_uart_rx_byte.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, data width and counter sizing.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam int DATA_BITS = 8;
  function automatic int cnt_width(input int div);
    return $clog2(div);
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: rx synchronizer chain (reset to idle-high) with falling-edge strobe.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rxs,
  output logic fall
);
  logic [SYNC_STAGES:0] q;
  always_ff @(posedge clk)
    if (reset) q <= '1;
    else q <= {q[SYNC_STAGES-1:0], rx};
  assign rxs = q[SYNC_STAGES-1];
  assign fall = q[SYNC_STAGES] & ~rxs;
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with valid/ready output; UART_RX_PARITY_EN selects 8E1.
module uart_rx_byte import uart_pkg::*; #(
  parameter int CLK_DIVIDER = 50,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);
  localparam int CW = cnt_width(CLK_DIVIDER);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIVIDER / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIVIDER - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic rxs, fall, tick, done, bad;
  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .reset(reset), .rx(rx), .rxs(rxs), .fall(fall));
  assign tick = cnt == '0;
  assign done = state == STOP && tick && rxs;
  assign bad = state == STOP && tick && !rxs;
`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_n;
  always_ff @(posedge clk)
    if (reset) par_bad <= 1'b0;
    else par_bad <= par_bad_n;
  assign parity_err = done && par_bad;
`else
  assign parity_err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = tick ? cnt : cnt - 1'b1;
    idx_n = idx;
    shift_n = shift;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
`endif
    case (state)
      IDLE: if (fall) begin state_n = START; cnt_n = HALF; end
      START: if (tick) begin state_n = rxs ? IDLE : DATA; cnt_n = FULL; idx_n = '0; end
      DATA: if (tick) begin
        shift_n = {rxs, shift[7:1]};
        cnt_n = FULL;
        idx_n = idx + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (idx == 3'(DATA_BITS - 1)) state_n = PARITY;
`else
        if (idx == 3'(DATA_BITS - 1)) state_n = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin par_bad_n = ^shift ^ rxs; cnt_n = FULL; state_n = STOP; end
`endif
      STOP: if (tick) state_n = rxs ? IDLE : BREAK;
      BREAK: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      if (done && (!rx_valid || rx_ready)) begin
        rx_data <= shift;
        rx_valid <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
      frame_err <= bad;
      overrun <= done && rx_valid && !rx_ready;
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: randomized self-checking bench for uart_rx_byte against a frame-level model.
module tb_uart_rx_byte;
  localparam int DIV = 50;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam int LAT = SYNC + DIV / 2 + 10 * DIV + 1;
`else
  localparam int NBITS = 10;
  localparam int LAT = SYNC + DIV / 2 + 9 * DIV + 1;
`endif
  logic clk = 0, reset = 1, rx = 1, rx_ready = 1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, parity_err;
  int checks = 0, failures = 0, cyc = 0, start_cyc = 0;
  int n_rise = 0, n_vcyc = 0, n_fe = 0, n_ov = 0, n_pe = 0, rise_cyc = 0;
  logic prev_valid = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  uart_rx_byte #(.CLK_DIVIDER(DIV), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (n_rise == 0) rise_cyc = cyc;
      n_rise++;
    end
    if (rx_valid === 1'b1) n_vcyc++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) got.push_back(rx_data);
    if (frame_err === 1'b1) n_fe++;
    if (overrun === 1'b1) n_ov++;
    if (parity_err === 1'b1) n_pe++;
    prev_valid = rx_valid;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear();
    got.delete();
    exp_q.delete();
    n_rise = 0; n_vcyc = 0; n_fe = 0; n_ov = 0; n_pe = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok);
    logic [10:0] f;
`ifdef UART_RX_PARITY_EN
    f = {stop, (^b) ^ ~par_ok, b, 1'b0};
`else
    f = {1'b1, stop, b, 1'b0};
`endif
    @(posedge clk); #1;
    start_cyc = cyc;
    for (int i = 0; i < NBITS; i++) begin
      rx = f[i];
      step(DIV);
    end
  endtask

  task automatic check_got(input string name);
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d bytes want %0d", name, got.size(), exp_q.size());
    end else
      foreach (exp_q[i]) if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_byte%0d: got %02h want %02h", name, i, got[i], exp_q[i]);
      end
  endtask

  task automatic test_reset();
    reset = 1;
    step(3);
    checks++;
    if ({rx_data, rx_valid, frame_err, overrun, parity_err} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got data=%02h v=%b fe=%b ov=%b pe=%b want all 0",
               rx_data, rx_valid, frame_err, overrun, parity_err);
    end
    reset = 0;
    step(5);
  endtask

  task automatic test_latency();
    clear();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1, 1);
    step(5);
    check_got("latency");
    checks++;
    if (rise_cyc - start_cyc != LAT) begin
      failures++;
      $display("FAIL latency_cycles: got %0d want %0d", rise_cyc - start_cyc, LAT);
    end
    checks++;
    if (n_vcyc != 1) begin failures++; $display("FAIL latency_valid_cycles: got %0d want 1", n_vcyc); end
    checks++;
    if (n_fe + n_ov + n_pe != 0) begin
      failures++;
      $display("FAIL latency_flags: got fe=%0d ov=%0d pe=%0d want 0", n_fe, n_ov, n_pe);
    end
  endtask

  task automatic test_glitch();
    clear();
    rx = 0;
    step(10);
    rx = 1;
    step(2 * DIV);
    checks++;
    if (n_rise + n_fe + n_ov + n_pe != 0) begin
      failures++;
      $display("FAIL glitch_quiet: got v=%0d fe=%0d ov=%0d pe=%0d want 0", n_rise, n_fe, n_ov, n_pe);
    end
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1, 1);
    step(5);
    check_got("glitch_next");
  endtask

  task automatic test_break();
    clear();
    send_frame(8'h0F, 0, 1);
    step(200);
    checks++;
    if (n_fe != 1 || n_rise != 0) begin
      failures++;
      $display("FAIL break_frame_err: got fe=%0d v=%0d want fe=1 v=0", n_fe, n_rise);
    end
    rx = 1;
    step(2 * DIV);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1, 1);
    step(5);
    check_got("break_next");
    checks++;
    if (n_fe != 1 || n_ov + n_pe != 0) begin
      failures++;
      $display("FAIL break_flags: got fe=%0d ov=%0d pe=%0d want fe=1 ov=0 pe=0", n_fe, n_ov, n_pe);
    end
  endtask

  task automatic test_back_to_back();
    clear();
    rx_ready = 0;
    send_frame(8'h01, 1, 1);
    send_frame(8'h02, 1, 1);
    step(5);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin
      failures++;
      $display("FAIL b2b_held: got v=%b data=%02h want v=1 data=01", rx_valid, rx_data);
    end
    checks++;
    if (n_ov != 1) begin failures++; $display("FAIL b2b_overrun: got %0d pulses want 1", n_ov); end
    rx_ready = 1;
    step(1);
    rx_ready = 0;
    step(1);
    checks++;
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL b2b_drop: got v=%b want 0", rx_valid); end
    exp_q.push_back(8'h01);
    check_got("b2b_accept");
    rx_ready = 1;
  endtask

  task automatic test_reset_mid();
    clear();
    fork
      send_frame(8'hFF, 1, 1);
      begin
        step(200);
        reset = 1;
        step(1);
        reset = 0;
        checks++;
        if ({rx_data, rx_valid, frame_err, overrun, parity_err} !== 12'h000) begin
          failures++;
          $display("FAIL midreset_outputs: got data=%02h v=%b fe=%b ov=%b pe=%b want all 0",
                   rx_data, rx_valid, frame_err, overrun, parity_err);
        end
      end
    join
    step(DIV);
    checks++;
    if (n_rise + n_fe + n_ov + n_pe != 0) begin
      failures++;
      $display("FAIL midreset_quiet: got v=%0d fe=%0d ov=%0d pe=%0d want 0", n_rise, n_fe, n_ov, n_pe);
    end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1, 1);
    step(5);
    check_got("midreset_next");
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit run;
    clear();
    run = 1;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          b = 8'($urandom);
          exp_q.push_back(b);
          send_frame(b, 1, 1);
          step($urandom_range(0, 2 * DIV));
        end
        step(10);
        run = 0;
      end
      while (run) begin
        rx_ready = 1'($urandom);
        step(1);
      end
    join
    rx_ready = 1;
    step(3);
    check_got("random");
    checks++;
    if (n_fe + n_ov + n_pe != 0) begin
      failures++;
      $display("FAIL random_flags: got fe=%0d ov=%0d pe=%0d want 0", n_fe, n_ov, n_pe);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear();
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1, 0);
    step(5);
    check_got("parity_bad");
    checks++;
    if (n_pe != 1) begin failures++; $display("FAIL parity_bad_pulse: got %0d want 1", n_pe); end
    clear();
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1, 1);
    step(5);
    check_got("parity_good");
    checks++;
    if (n_pe != 0) begin failures++; $display("FAIL parity_good_pulse: got %0d want 0", n_pe); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
